// File: rtl/led_pattern_master.sv
// LED pattern master: every TICK_DIV cycles computes the next LED pattern,
// writes it to an Avalon-MM slave, reads it back and compares. Mismatches
// and bus stalls longer than TIMEOUT cycles raise a sticky error flag and
// bump a saturating error counter.
module led_pattern_master #(
   parameter int TICK_DIV = 1000,
   parameter int TIMEOUT  = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  mode,
   output logic [2:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic        avm_read_n,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic [7:0]  pattern,
   output logic        busy,
   output logic        error,
   output logic [7:0]  err_count
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_CHECK = 3'd4;

   // Terminal counts; the tick counter is wide enough for TICK_DIV up to 2^24.
   localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
   localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

   logic [2:0]  r_state;
   logic [23:0] r_tick_cnt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  r_pattern;
   logic [7:0]  r_rd;
   logic        r_suppress;
   logic        r_error;
   logic [7:0]  r_err_count;

   logic [7:0]  w_next_pattern;
   logic        w_onehot;
   logic        w_in_write;
   logic        w_in_read;
   logic        w_in_check;
   logic        w_timeout;
   logic [7:0]  w_err_count_inc;
   logic        w_unused_rdata;

   // Only the low byte of the read data is ever compared.
   assign w_unused_rdata = ^avm_readdata[31:8];

   assign w_onehot        = (r_pattern != 8'h00) && ((r_pattern & (r_pattern - 8'd1)) == 8'h00);
   assign w_err_count_inc = (r_err_count == 8'hFF) ? 8'hFF : r_err_count + 8'd1;
   // Stall has lasted TIMEOUT cycles once this cycle is also stalled.
   assign w_timeout       = avm_waitrequest && (r_wait_cnt == WAIT_LAST);

   // Bus strobes are pure state decodes, so an asynchronous reset of the
   // state register drops them in the same cycle.
   assign w_in_write     = (r_state == ST_WRITE);
   assign w_in_read      = (r_state == ST_READ);
   assign w_in_check     = (r_state == ST_CHECK);
   assign avm_chipselect = w_in_write | w_in_read;
   assign avm_write_n    = ~w_in_write;
   assign avm_read_n     = ~w_in_read;
   assign avm_address    = 3'b000;
   assign avm_writedata  = {24'h000000, r_pattern};
   assign pattern        = r_pattern;
   assign busy           = w_in_write | w_in_read | w_in_check;
   assign error          = r_error;
   assign err_count      = r_err_count;

   // Next pattern for the currently selected mode (mode 3 behaves as mode 1).
   always_comb begin
      w_next_pattern = r_pattern + 8'd1;
      case (mode)
         2'd0:    w_next_pattern = w_onehot ? {r_pattern[6:0], r_pattern[7]} : 8'h01;
         2'd2:    w_next_pattern = (r_pattern == 8'h55) ? 8'hAA : 8'h55;
         default: w_next_pattern = r_pattern + 8'd1;
      endcase
   end

   // Sequencer: tick wait, write, read-back, compare; error bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_wait_cnt  <= '0;
         r_pattern   <= '0;
         r_rd        <= '0;
         r_suppress  <= 1'b0;
         r_error     <= 1'b0;
         r_err_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_tick_cnt <= '0;
               if (enable) begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (!enable) begin
                  r_tick_cnt <= '0;
                  r_state    <= ST_IDLE;
               end else if (r_tick_cnt == TICK_LAST) begin
                  // Mode is only looked at here, never during a transfer.
                  r_tick_cnt <= '0;
                  r_pattern  <= w_next_pattern;
                  r_wait_cnt <= '0;
                  r_state    <= ST_WRITE;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 24'd1;
               end
            end
            ST_WRITE: begin
               if (!avm_waitrequest) begin
                  r_wait_cnt <= '0;
                  r_state    <= ST_READ;
               end else if (w_timeout) begin
                  r_wait_cnt  <= '0;
                  r_suppress  <= 1'b1;
                  r_error     <= 1'b1;
                  r_err_count <= w_err_count_inc;
                  r_state     <= ST_CHECK;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            ST_READ: begin
               if (!avm_waitrequest) begin
                  r_rd       <= avm_readdata[7:0];
                  r_wait_cnt <= '0;
                  r_state    <= ST_CHECK;
               end else if (w_timeout) begin
                  r_wait_cnt  <= '0;
                  r_suppress  <= 1'b1;
                  r_error     <= 1'b1;
                  r_err_count <= w_err_count_inc;
                  r_state     <= ST_CHECK;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            ST_CHECK: begin
               // A timed-out transfer was already counted; skip the compare.
               if (!r_suppress && (r_rd != r_pattern)) begin
                  r_error     <= 1'b1;
                  r_err_count <= w_err_count_inc;
               end
               r_suppress <= 1'b0;
               r_state    <= enable ? ST_WAIT : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_pattern_master.sv
// Bench for led_pattern_master: register-slave bus model with configurable
// stalls and read corruption, scoreboard of expected writes, directed checks.
module tb_led_pattern_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  mode;
   logic [2:0]  avm_address;
   logic        avm_chipselect;
   logic        avm_write_n;
   logic        avm_read_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;
   logic [7:0]  pattern;
   logic        busy;
   logic        error;
   logic [7:0]  err_count;

   led_pattern_master #(.TICK_DIV(4), .TIMEOUT(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .mode            (mode),
      .avm_address     (avm_address),
      .avm_chipselect  (avm_chipselect),
      .avm_write_n     (avm_write_n),
      .avm_read_n      (avm_read_n),
      .avm_writedata   (avm_writedata),
      .avm_readdata    (avm_readdata),
      .avm_waitrequest (avm_waitrequest),
      .pattern         (pattern),
      .busy            (busy),
      .error           (error),
      .err_count       (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave model: one 8-bit register, programmable stalls.
   logic [7:0] slave_reg = 8'h00;
   int  wcnt = 0;
   int  rcnt = 0;
   int  wr_stall = 0;
   int  rd_stall = 0;
   bit  stuck_wr = 1'b0;
   bit  stuck_rd = 1'b0;
   bit  inv = 1'b0;
   logic mon_w_act;
   logic mon_r_act;

   assign mon_w_act = avm_chipselect && !avm_write_n;
   assign mon_r_act = avm_chipselect && !avm_read_n;
   assign avm_waitrequest = (mon_w_act && (stuck_wr || (wcnt < wr_stall))) ||
                            (mon_r_act && (stuck_rd || (rcnt < rd_stall)));
   assign avm_readdata = {24'h000000, slave_reg ^ {7'b0, inv}};

   always @(posedge clk) begin
      wcnt <= mon_w_act ? wcnt + 1 : 0;
      rcnt <= mon_r_act ? rcnt + 1 : 0;
      if (mon_w_act && !avm_waitrequest) slave_reg <= avm_writedata[7:0];
   end

   typedef struct {
      logic [7:0] data;
      int         at;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   next_at = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d, input int gap, input logic e, input logic [7:0] c);
      exp_t x;
      next_at = next_at + gap;
      x.data = d;
      x.at   = next_at;
      x.err  = e;
      x.cnt  = c;
      sb.push_back(x);
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         0:       return !busy;
         1:       return mon_w_act;
         2:       return mon_r_act;
         3:       return mon_w_act && (avm_writedata == 32'h0);
         default: return avm_chipselect;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int maxc, input string what);
      int n = 0;
      while (!cond(sel) && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cond(sel)) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_%s: not reached within %0d cycles", what, maxc);
      end
   endtask

   task automatic wait_sb_empty(input int maxc);
      int n = 0;
      while (sb.size() != 0 && n < maxc) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL sb_drain: %0d writes still outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: checks every accepted write against the scoreboard and
   // checks that address/data/strobes hold while the slave stalls.
   initial begin
      exp_t       e;
      bit         prev_w_stall = 1'b0;
      bit         prev_r_stall = 1'b0;
      logic [31:0] prev_wdata  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_w_stall = 1'b0;
            prev_r_stall = 1'b0;
         end else begin
            if (mon_w_act && prev_w_stall) begin
               check("stall_wdata", avm_writedata, prev_wdata);
               check("stall_wstrobes", {avm_chipselect, avm_read_n, avm_address}, 5'b11000);
            end
            if (mon_r_act && prev_r_stall) begin
               check("stall_rstrobes", {avm_chipselect, avm_write_n, avm_address}, 5'b11000);
            end
            if (mon_w_act && !avm_waitrequest) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_bad++;
                  $display("FAIL unexpected_write: got %0h, expected no write", avm_writedata);
               end else begin
                  e = sb.pop_front();
                  $display("write %02h at cycle %0d err=%0d cnt=%0d", avm_writedata[7:0], cyc, error, err_count);
                  check("wdata", avm_writedata, {24'h0, e.data});
                  check("write_cycle", cyc, e.at);
                  check("error_at_write", error, e.err);
                  check("err_count_at_write", err_count, e.cnt);
                  check("no_read_during_write", avm_read_n, 1);
               end
            end
            prev_w_stall = mon_w_act && avm_waitrequest;
            prev_r_stall = mon_r_act && avm_waitrequest;
            prev_wdata   = avm_writedata;
         end
      end
   end

   initial begin
      #300us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      int n;
      int m;
      bit seen;
      reset  = 1'b1;
      enable = 1'b0;
      mode   = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs", avm_chipselect, 0);
      check("rst_write_n", avm_write_n, 1);
      check("rst_read_n", avm_read_n, 1);
      check("rst_address", avm_address, 0);
      check("rst_wdata", avm_writedata, 0);
      check("rst_pattern", pattern, 0);
      check("rst_busy", busy, 0);
      check("rst_error", error, 0);
      check("rst_err_count", err_count, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);
      check("idle_cs", avm_chipselect, 0);

      // Walking one, 7-cycle period, first write TICK_DIV+1 after enable.
      enable  = 1'b1;
      next_at = cyc;
      push(8'h01, 5, 1'b0, 8'd0);
      for (int i = 1; i < 8; i++) push(8'(1 << i), 7, 1'b0, 8'd0);
      push(8'h01, 7, 1'b0, 8'd0);
      wait_sb_empty(100);

      // Binary counter up through FE, FF, 00; then alternate mode mid-WRITE.
      mode = 2'd1;
      for (int v = 2; v <= 256; v++) push(8'(v), 7, 1'b0, 8'd0);
      wait_for(3, 2500, "zero_write");
      mode = 2'd2;
      push(8'h55, 7, 1'b0, 8'd0);
      push(8'hAA, 7, 1'b0, 8'd0);
      wait_sb_empty(100);

      // Stalls: 3 cycles in WRITE, 2 in READ -> period TICK_DIV+8.
      wait_for(0, 20, "wait_tick_s3");
      wr_stall = 3;
      rd_stall = 2;
      next_at  = cyc;
      push(8'h55, 7, 1'b0, 8'd0);
      push(8'hAA, 12, 1'b0, 8'd0);
      push(8'h55, 12, 1'b0, 8'd0);
      wait_sb_empty(100);

      // Corrupted read-back: one error per update, saturating at FF.
      wait_for(0, 20, "wait_tick_s4");
      wr_stall = 0;
      rd_stall = 0;
      inv      = 1'b1;
      next_at  = cyc;
      for (int k = 0; k <= 300; k++)
         push((k % 2 == 0) ? 8'hAA : 8'h55, (k == 0) ? 4 : 7, k > 0, (k < 255) ? 8'(k) : 8'hFF);
      wait_sb_empty(2500);
      wait_for(0, 20, "wait_tick_s4_end");
      check("sat_err_count", err_count, 8'hFF);
      check("sat_error", error, 1);

      // Reset asserted during a stalled WRITE.
      inv      = 1'b0;
      wr_stall = 3;
      wait_for(1, 20, "write_s6");
      reset = 1'b1;
      #1;
      check("mid_rst_cs", avm_chipselect, 0);
      check("mid_rst_write_n", avm_write_n, 1);
      check("mid_rst_read_n", avm_read_n, 1);
      check("mid_rst_wdata", avm_writedata, 0);
      check("mid_rst_pattern", pattern, 0);
      check("mid_rst_err_count", err_count, 0);
      check("mid_rst_error", error, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1;
      wr_stall = 0;
      stuck_wr = 1'b1;
      reset    = 1'b0;

      // WRITE stuck: timeout after 8 cycles, then back to WAIT_TICK.
      wait_for(4, 20, "cs_s5");
      n = 0;
      while (avm_chipselect && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check("wr_timeout_len", n, 8);
      check("wr_timeout_strobes", {avm_chipselect, avm_write_n, avm_read_n}, 3'b011);
      check("wr_timeout_error", error, 1);
      check("wr_timeout_err_count", err_count, 1);
      check("wr_timeout_check_busy", busy, 1);
      @(posedge clk); #1;
      check("resume_busy", busy, 0);
      m = 0;
      while (!avm_chipselect && m < 20) begin
         m++;
         @(posedge clk); #1;
      end
      check("resume_wait_len", m, 4);

      // Write goes through, READ stuck, enable dropped during READ.
      stuck_wr = 1'b0;
      stuck_rd = 1'b1;
      next_at  = cyc;
      push(8'hAA, 0, 1'b1, 8'd1);
      wait_for(2, 5, "read_s5");
      enable = 1'b0;
      n = 0;
      while (!avm_read_n && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      check("rd_timeout_len", n, 8);
      check("rd_timeout_check_busy", busy, 1);
      check("rd_timeout_err_count", err_count, 2);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (busy || avm_chipselect) seen = 1'b1;
      end
      check("idle_after_drop", seen, 0);
      check("idle_after_drop_busy", busy, 0);
      wait_sb_empty(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
